// File: rtl/morse_pkg.sv
// Shared types, unit multiples and the PS/2 set-2 scan-code to Morse lookup
// used by the Morse sequencer.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE,
        MARK,
        ELEM_GAP,
        CHAR_GAP,
        WORD_GAP
    } state_t;

    typedef enum logic [1:0] {
        K_UNKNOWN,
        K_PATTERN,
        K_SPACE
    } kind_t;

    // bits are left-aligned: element 0 is bits[4], 1 = dash
    typedef struct packed {
        kind_t      kind;
        logic [2:0] len;
        logic [4:0] bits;
    } lookup_t;

    localparam logic [2:0] U_DOT        = 3'd1;
    localparam logic [2:0] U_DASH       = 3'd3;
    localparam logic [2:0] U_ELEM_GAP   = 3'd1;
    localparam logic [2:0] U_CHAR_GAP   = 3'd3;
    localparam logic [2:0] U_WORD_EXTRA = 3'd4;

    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_BREAK = 8'hF0;
    localparam logic [7:0] CODE_EXT   = 8'hE0;

    function automatic lookup_t mk(input logic [2:0] len, input logic [4:0] bits);
        lookup_t r;
        r.kind = K_PATTERN;
        r.len  = len;
        r.bits = bits;
        return r;
    endfunction

    function automatic lookup_t morse_lookup(input logic [7:0] code);
        lookup_t r;
        r.kind = K_UNKNOWN;
        r.len  = 3'd0;
        r.bits = 5'd0;
        case (code)
            8'h1C: r = mk(3'd2, 5'b01000); // A
            8'h32: r = mk(3'd4, 5'b10000); // B
            8'h21: r = mk(3'd4, 5'b10100); // C
            8'h23: r = mk(3'd3, 5'b10000); // D
            8'h24: r = mk(3'd1, 5'b00000); // E
            8'h2B: r = mk(3'd4, 5'b00100); // F
            8'h34: r = mk(3'd3, 5'b11000); // G
            8'h33: r = mk(3'd4, 5'b00000); // H
            8'h43: r = mk(3'd2, 5'b00000); // I
            8'h3B: r = mk(3'd4, 5'b01110); // J
            8'h42: r = mk(3'd3, 5'b10100); // K
            8'h4B: r = mk(3'd4, 5'b01000); // L
            8'h3A: r = mk(3'd2, 5'b11000); // M
            8'h31: r = mk(3'd2, 5'b10000); // N
            8'h44: r = mk(3'd3, 5'b11100); // O
            8'h4D: r = mk(3'd4, 5'b01100); // P
            8'h15: r = mk(3'd4, 5'b11010); // Q
            8'h2D: r = mk(3'd3, 5'b01000); // R
            8'h1B: r = mk(3'd3, 5'b00000); // S
            8'h2C: r = mk(3'd1, 5'b10000); // T
            8'h3C: r = mk(3'd3, 5'b00100); // U
            8'h2A: r = mk(3'd4, 5'b00010); // V
            8'h1D: r = mk(3'd3, 5'b01100); // W
            8'h22: r = mk(3'd4, 5'b10010); // X
            8'h35: r = mk(3'd4, 5'b10110); // Y
            8'h1A: r = mk(3'd4, 5'b11000); // Z
            8'h45: r = mk(3'd5, 5'b11111); // 0
            8'h16: r = mk(3'd5, 5'b01111); // 1
            8'h1E: r = mk(3'd5, 5'b00111); // 2
            8'h26: r = mk(3'd5, 5'b00011); // 3
            8'h25: r = mk(3'd5, 5'b00001); // 4
            8'h2E: r = mk(3'd5, 5'b00000); // 5
            8'h36: r = mk(3'd5, 5'b10000); // 6
            8'h3D: r = mk(3'd5, 5'b11000); // 7
            8'h3E: r = mk(3'd5, 5'b11100); // 8
            8'h46: r = mk(3'd5, 5'b11110); // 9
            CODE_SPACE: r.kind = K_SPACE;
            CODE_BREAK, CODE_EXT: r.kind = K_UNKNOWN;
            default: r.kind = K_UNKNOWN;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/morse_sequencer_if.sv
// Character handshake between the keyboard buffer and the Morse sequencer.
interface morse_sequencer_if;
    logic [7:0] sym_data;
    logic       sym_valid;
    logic       sym_ready;

    modport master (output sym_data, output sym_valid, input sym_ready);
    modport slave  (input sym_data, input sym_valid, output sym_ready);
endinterface

// File: rtl/morse_unit_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
module morse_unit_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign done = (count_q == '0);
endmodule

// File: rtl/morse_sequencer.sv
// Turns accepted scan codes into keyed Morse timing on morse_code_out,
// with ITU element, character and word spacing measured in units.
module morse_sequencer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 1200000
) (
    input  logic              clk,
    input  logic              rst,
    morse_sequencer_if.slave  sym,
    output logic              morse_code_out,
    output logic              busy
);
    localparam int CW = $clog2(UNIT_CYCLES * 4);

    state_t     state_q, state_d;
    logic [4:0] pat_q, pat_d;
    logic [2:0] len_q, len_d;
    logic [2:0] idx_q, idx_d;
    logic       out_q, out_d;

    logic          load;
    logic [2:0]    load_units;
    logic [CW-1:0] load_val;
    logic          done;
    lookup_t       lk;
    logic [4:0]    next_pat;
    logic [2:0]    idx_inc;

    assign load_val = CW'(32'(load_units) * 32'(UNIT_CYCLES) - 32'd1);
    assign idx_inc  = idx_q + 3'd1;
    assign next_pat = pat_q << idx_inc;

    morse_unit_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        idx_d      = idx_q;
        load       = 1'b0;
        load_units = U_DOT;
        lk         = morse_lookup(sym.sym_data);
        case (state_q)
            IDLE: begin
                if (sym.sym_valid) begin
                    case (lk.kind)
                        K_PATTERN: begin
                            state_d    = MARK;
                            pat_d      = lk.bits;
                            len_d      = lk.len;
                            idx_d      = 3'd0;
                            load       = 1'b1;
                            load_units = lk.bits[4] ? U_DASH : U_DOT;
                        end
                        K_SPACE: begin
                            state_d    = WORD_GAP;
                            load       = 1'b1;
                            load_units = U_WORD_EXTRA;
                        end
                        default: ; // unknown codes and prefixes are swallowed
                    endcase
                end
            end
            MARK: begin
                if (done) begin
                    load = 1'b1;
                    if (idx_inc < len_q) begin
                        state_d    = ELEM_GAP;
                        load_units = U_ELEM_GAP;
                    end else begin
                        state_d    = CHAR_GAP;
                        load_units = U_CHAR_GAP;
                    end
                end
            end
            ELEM_GAP: begin
                if (done) begin
                    state_d    = MARK;
                    idx_d      = idx_inc;
                    load       = 1'b1;
                    load_units = next_pat[4] ? U_DASH : U_DOT;
                end
            end
            CHAR_GAP: begin
                if (done) begin
                    state_d = IDLE;
                    pat_d   = 5'd0;
                    len_d   = 3'd0;
                    idx_d   = 3'd0;
                end
            end
            WORD_GAP: begin
                if (done)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        out_d = (state_d == MARK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= 5'd0;
            len_q   <= 3'd0;
            idx_q   <= 3'd0;
            out_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            out_q   <= out_d;
        end
    end

    assign morse_code_out = out_q;
    assign busy           = (state_q != IDLE);
    assign sym.sym_ready  = (state_q == IDLE);
endmodule

// File: tb/tb_morse_sequencer.sv
// Directed bench for morse_sequencer at UNIT_CYCLES=4: cycle-by-cycle
// expectations for mark/space timing, dropped codes, reset abort and noise.
module tb_morse_sequencer;
    localparam int U = 4;

    logic clk = 1'b0;
    logic rst;
    logic morse_code_out;
    logic busy;

    morse_sequencer_if sif();

    morse_sequencer #(.UNIT_CYCLES(U)) dut (
        .clk            (clk),
        .rst            (rst),
        .sym            (sif.slave),
        .morse_code_out (morse_code_out),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Check n consecutive cycles against constant out/busy/ready, then advance.
    task automatic seg(input string tag, input int n, input logic o, input logic b,
                       input logic r, input bit noise);
        $display("[TB] step %s: %0d cycles, out=%b busy=%b ready=%b", tag, n, o, b, r);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s[%0d].out", tag, i), morse_code_out, o);
            chk($sformatf("%s[%0d].busy", tag, i), busy, b);
            chk($sformatf("%s[%0d].ready", tag, i), sif.sym_ready, r);
            if (noise) begin
                sif.sym_data  = 8'($urandom);
                sif.sym_valid = 1'($urandom);
            end
            tick();
        end
    endtask

    // One-cycle handshake; afterwards the bench sits in cycle 1 of the transfer.
    task automatic send(input string tag, input logic [7:0] code);
        $display("[TB] send %s code=%02h", tag, code);
        sif.sym_data  = code;
        sif.sym_valid = 1'b1;
        chk({tag, ".hs_ready"}, sif.sym_ready, 1'b1);
        tick();
        sif.sym_valid = 1'b0;
    endtask

    initial begin
        rst           = 1'b1;
        sif.sym_data  = 8'h00;
        sif.sym_valid = 1'b0;
        tick();
        tick();
        chk("reset.out", morse_code_out, 1'b0);
        chk("reset.busy", busy, 1'b0);
        chk("reset.ready", sif.sym_ready, 1'b1);
        rst = 1'b0;
        seg("post_reset_idle", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // E: 4-cycle mark, 12-cycle char gap, ready again at cycle 17
        send("E", 8'h24);
        seg("E_mark", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("E_chargap", 12, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("E_idle", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // S: dot gap dot gap dot chargap = 32 busy cycles
        send("S", 8'h1B);
        seg("S_mark0", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("S_gap0", 4, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("S_mark1", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("S_gap1", 4, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("S_mark2", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("S_chargap", 12, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("S_idle", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // T, SPACE, E with sym_valid held high throughout
        $display("[TB] send T/SPACE/E back-to-back");
        sif.sym_data  = 8'h2C;
        sif.sym_valid = 1'b1;
        chk("T.hs_ready", sif.sym_ready, 1'b1);
        tick();
        sif.sym_data = 8'h29;
        seg("T_mark", 12, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("T_chargap", 12, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("SP_accept", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        sif.sym_data = 8'h24;
        seg("SP_wordgap", 16, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("E2_accept", 1, 1'b0, 1'b0, 1'b1, 1'b0);
        sif.sym_valid = 1'b0;
        seg("E2_mark", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("E2_chargap", 12, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("E2_idle", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // Unknown code and prefixes are swallowed without leaving IDLE
        send("NUL", 8'h00);
        seg("NUL_idle", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        send("BRK", 8'hF0);
        seg("BRK_idle", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        send("ENT", 8'h5A);
        seg("ENT_idle", 3, 1'b0, 1'b0, 1'b1, 1'b0);

        // O with reset pulsed at edge 20 (inside the second dash)
        send("O", 8'h44);
        seg("O_mark0", 12, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("O_gap0", 4, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("O_mark1_pre", 3, 1'b1, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seg("O_after_rst", 3, 1'b0, 1'b0, 1'b1, 1'b0);
        send("E3", 8'h24);
        seg("E3_mark", 4, 1'b1, 1'b1, 1'b0, 1'b0);
        seg("E3_chargap", 12, 1'b0, 1'b1, 1'b0, 1'b0);
        seg("E3_idle", 2, 1'b0, 1'b0, 1'b1, 1'b0);

        // 0: five dashes while sym_data/sym_valid toggle randomly
        send("ZERO", 8'h45);
        for (int d = 0; d < 5; d++) begin
            seg($sformatf("ZERO_mark%0d", d), 12, 1'b1, 1'b1, 1'b0, 1'b1);
            if (d < 4)
                seg($sformatf("ZERO_gap%0d", d), 4, 1'b0, 1'b1, 1'b0, 1'b1);
        end
        seg("ZERO_chargap", 12, 1'b0, 1'b1, 1'b0, 1'b1);
        sif.sym_valid = 1'b0;
        seg("ZERO_idle", 3, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 Parameter: UNIT_CYCLES, default 1200000, clock cycles per Morse time unit (legal range 2 .. 2^21-1).
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: sym_data  input  8  PS/2 set-2 make code of the character to send.
REQ-005 Port: sym_valid  input  1  sym_data holds a character to send.
REQ-006 Port: sym_ready  output  1  sequencer accepts a character this cycle.
REQ-007 Port: morse_code_out  output  1  keyed Morse signal; 1 = mark (tone), 0 = space.
REQ-008 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-009 The block SHALL accept a character on a cycle where sym_valid and sym_ready are both high (the handshake); sym_data is captured on that edge.
REQ-010 sym_ready SHALL be high only in IDLE and SHALL be driven from registered state, with no combinational dependency on sym_valid.
REQ-011 Capture lookup SHALL produce one of three results: pattern (length 1-5 elements, 1 = dash, sent MSB first), SPACE (code 0x29), or UNKNOWN.
REQ-012 Supported codes: A-Z and 0-9 per the package table, using ITU Morse patterns (e.g. E 0x24 = dot, T 0x2C = dash, S 0x1B = dot-dot-dot, O 0x44 = dash-dash-dash).
REQ-013 UNKNOWN codes, and 0xF0/0xE0 prefixes, SHALL be consumed and dropped: the state stays IDLE, there is no output, and sym_ready stays high.
REQ-014 States: IDLE, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP, encoded as a package enum.
REQ-015 IDLE + pattern handshake -> MARK on the next cycle, with the element index set to the first element.
REQ-016 IDLE + SPACE handshake -> WORD_GAP, which lasts 4 units; a word gap is therefore 7 units in total after the preceding CHAR_GAP.
REQ-017 MARK SHALL hold morse_code_out=1 for 1 unit (dot) or 3 units (dash).
REQ-018 MARK end: if elements remain -> ELEM_GAP; otherwise -> CHAR_GAP.
REQ-019 ELEM_GAP SHALL last 1 unit and then return to MARK with the element index advanced.
REQ-020 CHAR_GAP SHALL last 3 units and then go to IDLE; WORD_GAP end -> IDLE.
REQ-021 morse_code_out SHALL be registered and equal 1 exactly in MARK cycles.
REQ-022 A handshake at edge N SHALL give morse_code_out=1 from cycle N+1 (1 cycle latency).
REQ-023 Durations SHALL be counted by one down-counter of width clog2(UNIT_CYCLES*4), reloaded with (units*UNIT_CYCLES - 1) on each state entry; a state exits when the counter reaches 0.
REQ-024 The counter SHALL never wrap; the reload value for the maximum of 4 units SHALL fit in the counter width.
REQ-025 sym_valid held high with a new character SHALL be accepted on the first IDLE cycle after CHAR_GAP or WORD_GAP, with no extra idle cycle.
REQ-026 sym_data/sym_valid changes while not IDLE SHALL have no effect.

Reset
REQ-027 rst high at any clock edge SHALL force the following: state=IDLE, morse_code_out=0, busy=0, sym_ready=1 in the following cycle, counter=0, element index=0, latched pattern cleared.
REQ-028 Reset mid-character SHALL abort transmission immediately, with no residual mark; the first handshake after rst falls SHALL be honoured normally.

Structure
REQ-029 Package morse_pkg SHALL hold the state enum, the unit multiples (DOT=1, DASH=3, ELEM_GAP=1, CHAR_GAP=3, WORD_EXTRA=4), the SPACE/prefix code constants, and the scan-code-to-pattern lookup function returning {kind, length[2:0], bits[4:0]}.
REQ-030 One sub-module SHALL exist: morse_unit_timer (loadable down-counter with a done flag), instantiated once.
REQ-031 The block SHALL sit between data_control's buffer output and the uo_out[0] drive.

Verification (UNIT_CYCLES=4)
REQ-032 E (0x24) handshake at edge 0 -> out=1 cycles 1-4; out=0 cycles 5-16; sym_ready=1 at cycle 17; busy=1 cycles 1-16.
REQ-033 S (0x1B) -> three 4-cycle marks separated by 4-cycle spaces, then a 12-cycle gap; total 32 busy cycles.
REQ-034 T (0x2C), then 0x29, then E held valid back-to-back -> 12-cycle mark, 12+16 low cycles, E mark starting at the cycle after WORD_GAP ends.
REQ-035 0x00, 0xF0 and 0x5A each handshaken -> morse_code_out stays 0, busy stays 0, sym_ready stays 1 throughout.
REQ-036 O (0x44) with rst pulsed for 1 cycle during the second dash -> out=0 and busy=0 on the cycle after reset; a following E produces a clean 4-cycle mark.
REQ-037 sym_data toggled randomly while busy during 0 (0x45, five dashes) -> output matches the exact 0 pattern, 5x12 marks, with no extra handshake.
